adder_seq_arbiter: RTL

- Shares one `fulladder` slice (width+1 bits) between two requesters.
- Each requester submits a multi-limb addition job as a stream of limbs, least-significant limb first, terminated by a last flag.
- The block arbitrates between requesters round-robin, locks the grant for a whole job, and chains carry-out into carry-in across limbs.
- Results leave through a registered valid/ready output stage tagged with the requester id.

---
 rtl/adder_seq_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/adder_seq_arbiter.sv
// adder_seq_arbiter: two requesters share one full-adder slice for multi-limb
// additions. A requester is granted round-robin and keeps the grant for a
// whole job. Carry is chained across limbs, and each result limb leaves
// through a registered valid/ready stage tagged with the owner id.

// Combinational (width+1)-bit adder slice with carry in and carry out.
module fulladder #(
  parameter int width = 2
) (
  input  logic [width:0] i_a,
  input  logic [width:0] i_b,
  input  logic           i_c_in,
  output logic [width:0] o_sum,
  output logic           o_c_out
);

  // Sum is one bit wider than the operands so the carry falls out of the top.
  always_comb begin
    {o_c_out, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{(width + 1){1'b0}}, i_c_in};
  end

endmodule

module adder_seq_arbiter #(
  parameter int width = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in0_valid,
  output logic           in0_ready,
  input  logic [width:0] in0_a,
  input  logic [width:0] in0_b,
  input  logic           in0_c_in,
  input  logic           in0_last,
  input  logic           in1_valid,
  output logic           in1_ready,
  input  logic [width:0] in1_a,
  input  logic [width:0] in1_b,
  input  logic           in1_c_in,
  input  logic           in1_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [width:0] out_sum,
  output logic           out_c_out,
  output logic           out_last,
  output logic           out_id
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic           r_gnt;
  logic           r_first;
  logic           r_carry;
  logic           r_last_grant;

  logic           r_out_valid;
  logic [width:0] r_out_sum;
  logic           r_out_c_out;
  logic           r_out_last;
  logic           r_out_id;

  logic           w_gnt_valid;
  logic [width:0] w_gnt_a;
  logic [width:0] w_gnt_b;
  logic           w_gnt_c_in;
  logic           w_gnt_last;
  logic           w_gnt_ready;
  logic           w_fire;
  logic           w_arb_req;
  logic           w_arb_pick;
  logic           w_fa_c_in;
  logic [width:0] w_fa_sum;
  logic           w_fa_c_out;

  // Select the input bundle of whichever requester currently holds the grant.
  always_comb begin
    if (r_gnt) begin
      w_gnt_valid = in1_valid;
      w_gnt_a     = in1_a;
      w_gnt_b     = in1_b;
      w_gnt_c_in  = in1_c_in;
      w_gnt_last  = in1_last;
    end else begin
      w_gnt_valid = in0_valid;
      w_gnt_a     = in0_a;
      w_gnt_b     = in0_b;
      w_gnt_c_in  = in0_c_in;
      w_gnt_last  = in0_last;
    end
  end

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    w_arb_req = in0_valid | in1_valid;
    if (in0_valid & in1_valid) begin
      w_arb_pick = ~r_last_grant;
    end else if (in1_valid) begin
      w_arb_pick = 1'b1;
    end else begin
      w_arb_pick = 1'b0;
    end
  end

  // Accept a limb only while busy and the output stage can take a result.
  always_comb begin
    w_gnt_ready = (r_state == ST_BUSY) & (~r_out_valid | out_ready);
    w_fire      = w_gnt_valid & w_gnt_ready;
    in0_ready   = w_gnt_ready & ~r_gnt;
    in1_ready   = w_gnt_ready & r_gnt;
    w_fa_c_in   = r_first ? w_gnt_c_in : r_carry;
  end

  fulladder #(
    .width (width)
  ) u_fulladder (
    .i_a     (w_gnt_a),
    .i_b     (w_gnt_b),
    .i_c_in  (w_fa_c_in),
    .o_sum   (w_fa_sum),
    .o_c_out (w_fa_c_out)
  );

  // FSM next state: IDLE arbitrates, BUSY runs until the last limb fires.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_req) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_fire & w_gnt_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant, first-limb flag, chained carry and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt        <= 1'b0;
      r_first      <= 1'b1;
      r_carry      <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (r_state == ST_IDLE) begin
      if (w_arb_req) begin
        r_gnt   <= w_arb_pick;
        r_first <= 1'b1;
      end
    end else if (w_fire) begin
      r_carry <= w_fa_c_out;
      r_first <= w_gnt_last;
      if (w_gnt_last) begin
        r_last_grant <= r_gnt;
      end
    end
  end

  // Output stage: load on fire (also when draining), clear valid on a pure drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= {(width + 1){1'b0}};
      r_out_c_out <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_id    <= 1'b0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_fa_sum;
      r_out_c_out <= w_fa_c_out;
      r_out_last  <= w_gnt_last;
      r_out_id    <= r_gnt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_comb begin
    out_valid = r_out_valid;
    out_sum   = r_out_sum;
    out_c_out = r_out_c_out;
    out_last  = r_out_last;
    out_id    = r_out_id;
  end

endmodule
